// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl
//   Drains the ps2_keyboard receive FIFO one byte at a time through the
//   ready / nextdata_n handshake. It decodes PS/2 Set-2 E0 (extended) and F0
//   (break) prefixes into single key events, tracks the held key, counts new
//   presses and keeps a sticky FIFO-overflow flag.
//
//   Optional feature macro: PS2_SCAN_REPEAT_EN
//     defined   - a typematic repeat make pulses key_valid (key_down=1)
//     undefined - a repeat make is consumed silently
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ready      FIFO non-empty
//   data       FIFO head byte, valid while ready=1
//   overflow   FIFO overflow indication
//   nextdata_n active-low pop strobe, low for the single ACK cycle per byte
//   key_code   scan code of the last emitted event
//   key_ext    last event was E0-prefixed
//   key_down   last event was a make (1) or a break (0)
//   key_valid  one-cycle pulse per emitted event
//   key_held   last made key not yet released
//   key_cnt    count of new (non-repeat) make events, wraps
//   err_ovf    sticky overflow flag, cleared only by rst

module ps2_scan_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             key_valid,
    output logic             key_held,
    output logic [CNT_W-1:0] key_cnt,
    output logic             err_ovf
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAck  = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       byte_q;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [7:0]       code_q, code_d;
    logic             kext_q, kext_d;
    logic             down_q, down_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [7:0]       hcode_q, hcode_d;
    logic             hext_q, hext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             match;

    // Event refers to the key currently held down.
    assign match = held_q && (hcode_q == byte_q) && (hext_q == ext_q);

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        kext_d  = kext_q;
        down_d  = down_q;
        valid_d = 1'b0;
        held_d  = held_q;
        hcode_d = hcode_q;
        hext_d  = hext_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | overflow;

        case (state_q)
            StIdle: begin
                if (ready) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StWait;
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (brk_q) begin
                        valid_d = 1'b1;
                        code_d  = byte_q;
                        kext_d  = ext_q;
                        down_d  = 1'b0;
                        if (match) begin
                            held_d = 1'b0;
                        end
                    end else if (!match) begin
                        valid_d = 1'b1;
                        code_d  = byte_q;
                        kext_d  = ext_q;
                        down_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        held_d  = 1'b1;
                        hcode_d = byte_q;
                        hext_d  = ext_q;
                    end else begin
`ifdef PS2_SCAN_REPEAT_EN
                        valid_d = 1'b1;
                        code_d  = byte_q;
                        kext_d  = ext_q;
                        down_d  = 1'b1;
`endif
                    end
                end
            end
            StWait: begin
                // ready is ignored here while the FIFO read pointer settles.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            byte_q  <= 8'h00;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            code_q  <= 8'h00;
            kext_q  <= 1'b0;
            down_q  <= 1'b0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            hcode_q <= 8'h00;
            hext_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && ready) begin
                byte_q <= data;
            end
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            code_q  <= code_d;
            kext_q  <= kext_d;
            down_q  <= down_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            hcode_q <= hcode_d;
            hext_q  <= hext_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Gated by rst so no pop is issued in a reset cycle.
    assign nextdata_n = !((state_q == StAck) && !rst);
    assign key_code   = code_q;
    assign key_ext    = kext_q;
    assign key_down   = down_q;
    assign key_valid  = valid_q;
    assign key_held   = held_q;
    assign key_cnt    = cnt_q;
    assign err_ovf    = ovf_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a queue-based FIFO model feeds the DUT,
// a key-event reference model predicts every key_valid pulse, and a monitor
// compares each pulse against the predicted event queue.

module tb_ps2_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic       key_valid;
    logic       key_held;
    logic [7:0] key_cnt;
    logic       err_ovf;

    ps2_scan_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .key_cnt    (key_cnt),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       down;
        logic       held;
        logic [7:0] cnt;
    } ev_t;

    logic [7:0] fifo[$];
    ev_t        sb[$];

    int n_chk = 0;
    int n_fail = 0;
    int pops = 0;
    int pushed = 0;

    // Reference model state
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic       m_held = 1'b0, m_hext = 1'b0;
    logic [7:0] m_hcode = 8'h00, m_cnt = 8'h00;
    logic [7:0] m_lcode = 8'h00;
    logic       m_lext = 1'b0, m_ldown = 1'b0, m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic emit(input logic [7:0] c, input logic e, input logic d);
        ev_t ev;
        ev.code = c;
        ev.ext  = e;
        ev.down = d;
        ev.held = m_held;
        ev.cnt  = m_cnt;
        sb.push_back(ev);
        m_lcode = c;
        m_lext  = e;
        m_ldown = d;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic same;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            same = m_held && m_hcode == b && m_hext == m_ext;
            if (m_brk) begin
                if (same) m_held = 1'b0;
                emit(b, m_ext, 1'b0);
            end else if (!same) begin
                m_cnt   = m_cnt + 8'd1;
                m_held  = 1'b1;
                m_hcode = b;
                m_hext  = m_ext;
                emit(b, m_ext, 1'b1);
            end else begin
`ifdef PS2_SCAN_REPEAT_EN
                emit(b, m_ext, 1'b1);
`endif
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 0; m_cnt = 0;
        m_lcode = 0; m_lext = 0; m_ldown = 0; m_err = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        pushed++;
        model_byte(b);
        ready = 1'b1;
        data  = fifo[0];
    endtask

    task automatic send_key(input logic [7:0] c, input logic e, input logic brk);
        if (e) push_byte(8'hE0);
        if (brk) push_byte(8'hF0);
        push_byte(c);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait for the FIFO to empty and the last event to land, then check
    // the steady outputs against the model.
    task automatic drain(input string tag);
        int budget = 6000;
        while (fifo.size() != 0 && budget > 0) begin
            step(1);
            budget--;
        end
        check({tag, "_drain_timeout"}, budget > 0, 1);
        step(5);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_pops"}, pops, pushed);
        check({tag, "_key_code"}, key_code, m_lcode);
        check({tag, "_key_ext"}, key_ext, m_lext);
        check({tag, "_key_down"}, key_down, m_ldown);
        check({tag, "_key_held"}, key_held, m_held);
        check({tag, "_key_cnt"}, key_cnt, m_cnt);
        check({tag, "_err_ovf"}, err_ovf, m_err);
        check({tag, "_nextdata_idle"}, nextdata_n, 1);
    endtask

    // FIFO model: pop on a posedge where nextdata_n was low.
    initial begin
        logic do_pop;
        forever begin
            @(negedge clk);
            do_pop = !nextdata_n;
            @(posedge clk);
            #1;
            if (do_pop && fifo.size() > 0) void'(fifo.pop_front());
            ready = (fifo.size() != 0);
            data  = ready ? fifo[0] : 8'h00;
        end
    end

    // Monitor: compare every key_valid pulse with the predicted event.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!nextdata_n) begin
                pops++;
                check("pop_while_ready", ready, 1);
            end
            if (key_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_key_valid", key_valid, 0);
                end else begin
                    ev = sb.pop_front();
                    check("ev_code", key_code, ev.code);
                    check("ev_ext", key_ext, ev.ext);
                    check("ev_down", key_down, ev.down);
                    check("ev_held", key_held, ev.held);
                    check("ev_cnt", key_cnt, ev.cnt);
                end
            end
        end
    end

    initial begin
        logic [7:0] tbl [6];
        int found;
        tbl[0] = 8'h1C; tbl[1] = 8'h1D; tbl[2] = 8'h75;
        tbl[3] = 8'h6B; tbl[4] = 8'h29; tbl[5] = 8'h5A;

        step(3);
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_key_code", key_code, 8'h00);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_cnt", key_cnt, 0);
        check("rst_err_ovf", err_ovf, 0);
        rst = 1'b0;
        step(2);

        push_byte(8'h1C);
        drain("single_make");
        check("single_cnt_is_1", key_cnt, 8'd1);
        check("single_held", key_held, 1);

        push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        drain("make_break");
        check("mb_released", key_held, 0);

        send_key(8'h75, 1'b1, 1'b0);
        send_key(8'h75, 1'b1, 1'b1);
        drain("ext_seq");
        check("ext_seq_ext", key_ext, 1);

        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
        drain("repeat");

        for (int i = 0; i < 80; i++) begin
            send_key(tbl[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 9) == 0) begin
                overflow = 1'b1;
                m_err = 1'b1;
                step(1);
                overflow = 1'b0;
            end
            step($urandom_range(0, 8));
        end
        drain("random");

        // Counter wrap from a fresh reset.
        rst = 1'b1; step(1); rst = 1'b0; model_reset();
        step(1);
        check("rst2_cnt", key_cnt, 0);
        for (int i = 0; i < 256; i++) begin
            send_key(8'((i % 128) + 1), 1'(i >= 128), 1'b0);
            send_key(8'((i % 128) + 1), 1'(i >= 128), 1'b1);
        end
        drain("wrap");
        check("wrap_cnt_zero", key_cnt, 8'h00);
        overflow = 1'b1; m_err = 1'b1; step(1); overflow = 1'b0;
        step(10);
        check("ovf_sticky", err_ovf, 1);

        // Reset while in WAIT after an F0 prefix: the prefix must be lost.
        push_byte(8'hF0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (!nextdata_n) found = 1;
        end
        check("f0_pop_seen", found, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_reset();
        check("rst3_err_ovf", err_ovf, 0);
        check("rst3_key_down", key_down, 0);
        push_byte(8'h1C);
        drain("prefix_discard");
        check("pd_down", key_down, 1);
        check("pd_cnt", key_cnt, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Sequencer sitting between the `ps2_keyboard` receive FIFO and the display/application logic. It drains the FIFO through the `ready`/`nextdata_n` handshake one byte at a time. It decodes PS/2 Set-2 prefixes (`E0` extended, `F0` break) into single key events and tracks held-key state. It also keeps a press counter and a sticky overflow flag for the 7-segment front end.

## Interface
Parameters:
- `CNT_W`, default 8: width of the key-press counter.

Ports:
- `clk`, in, 1: system clock; every register updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ready`, in, 1: FIFO non-empty, driven by `ps2_keyboard`.
- `data`, in, 8: FIFO head byte; valid while `ready`=1.
- `overflow`, in, 1: FIFO overflow indication from `ps2_keyboard`.
- `nextdata_n`, out, 1: active-low pop strobe to the FIFO.
- `key_code`, out, 8: scan code of the last emitted event.
- `key_ext`, out, 1: last event was `E0`-prefixed.
- `key_down`, out, 1: last event was a make (1) or a break (0).
- `key_valid`, out, 1: one-cycle pulse per emitted event.
- `key_held`, out, 1: the last made key has not yet been released.
- `key_cnt`, out, `CNT_W`: count of new (non-repeat) make events.
- `err_ovf`, out, 1: sticky; set once `overflow` has been seen.

## Operation
- FSM states and transitions:
  - IDLE → ACK when `ready`=1. On that edge, `data` is latched into `byte_q`.
  - ACK → WAIT unconditionally. `nextdata_n`=0 in ACK only, and `byte_q` is decoded here.
  - WAIT → IDLE unconditionally. `ready` is ignored in WAIT so the FIFO read pointer can settle.
- Decode of `byte_q` in ACK:
  - `E0`: set `ext_q`. No event.
  - `F0`: set `brk_q`. No event.
  - Any other byte: emit an event, then clear `ext_q` and `brk_q`.
- For an emitted event, the outputs load as `key_code`=`byte_q`, `key_ext`=`ext_q`, `key_down`=~`brk_q`.
- Make event, {code,ext} different from the held key or `key_held`=0:
  - new press; `key_valid` pulses.
  - `key_cnt` increments and wraps from 2^CNT_W−1 to 0.
  - held key := {code,ext}; `key_held`=1.
- Make event, {code,ext} equal to the held key and `key_held`=1: typematic repeat. `key_cnt` is unchanged; see Configuration for `key_valid`.
- Break event:
  - `key_valid` pulses.
  - If {code,ext} matches the held key, `key_held`:=0. Otherwise `key_held` is unchanged.
- `err_ovf` is set in any cycle where `overflow`=1 and cleared only by `rst`. Overflow does not alter decoding.
- When no event is emitted, `key_code`, `key_ext` and `key_down` hold their last values.

## Timing
- Reset values:
  - state=IDLE, `nextdata_n`=1.
  - `key_code`=8'h00, `key_ext`=0, `key_down`=0, `key_valid`=0.
  - `key_held`=0, `key_cnt`=0, `err_ovf`=0, `ext_q`=`brk_q`=0.
- Latency: with `ready` sampled 1 in IDLE at edge N, `nextdata_n`=0 during cycle N+1 (ACK) and `key_valid`=1 during cycle N+2 (WAIT).
- Throughput: one FIFO byte per 3 cycles. A break sequence `F0 xx` takes 6 cycles; `E0 F0 xx` takes 9 cycles.
- `nextdata_n` is low for exactly one cycle per byte and is never low while `ready`=0.
- `rst` mid-sequence: FSM returns to IDLE, a pending prefix is discarded, and no pop is issued in the reset cycle. An unconsumed FIFO byte is re-read after reset.
- Simultaneous `overflow` and event in the same cycle: both take effect.

## Configuration
- `PS2_SCAN_REPEAT_EN` defined: a typematic repeat make pulses `key_valid` with `key_down`=1. `key_cnt` and `key_held` are still unchanged.
- `PS2_SCAN_REPEAT_EN` undefined: a repeat make is consumed silently. There is no `key_valid` pulse and no output change.

## Test plan
- Reset then FIFO byte `1C` → `nextdata_n` low for one cycle, then `key_valid` pulse with `key_code`=1C, `key_down`=1, `key_ext`=0, `key_held`=1, `key_cnt`=1.
- Bytes `1C F0 1C` → two pulses. The second has `key_down`=0, and `key_held`=0 afterwards; `key_cnt`=1; exactly 3 `nextdata_n` strobes.
- Bytes `E0 75 E0 F0 75` → events (75, ext=1, down=1) then (75, ext=1, down=0). No pulses for prefixes.
- Bytes `1C 1C 1C` → `key_cnt`=1 throughout. Three pulses with `PS2_SCAN_REPEAT_EN`, one pulse without.
- 256 distinct make/break pairs with `CNT_W`=8 → `key_cnt` wraps to 0. Then `overflow` pulsed once → `err_ovf`=1 until `rst`.
- Byte `F0`, assert `rst` in WAIT, then byte `1C` → `key_down`=1 (prefix discarded), `key_cnt`=1.
